// File: rtl/clock_set_ctrl.sv
// ============================================================================
// clock_set_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for the calendar's chained time counters
// (seconds mod 60, minutes mod 60, hours mod 24).
//
// RUN mode:
//   The 1 Hz tick and the counter carries become per-counter increment
//   enables. Carries are sampled in the same cycle as the tick, so the
//   seconds, minutes and hours enables of a full rollover pulse together.
//
// SET modes (SET_HOUR, SET_MIN, SET_SEC):
//   The tick cascade is suppressed. A rising edge on the increment button
//   pulses the enable of the selected field only (seconds are zeroed via
//   sec_clr rather than incremented). The selected field blinks, and after
//   TIMEOUT ticks without any button edge the controller falls back to RUN.
//
// The mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
// Every output is registered: an event in cycle N shows up in cycle N+1
// as a single-cycle pulse.
//
// Parameters:
//   TIMEOUT  ticks without a button edge before SET mode exits to RUN
//   TW       width of the timeout counter, 2**TW must exceed TIMEOUT
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   tick       in   one-cycle pulse, once per second
//   btn_mode   in   mode button level (debounced, synchronised)
//   btn_inc    in   increment button level (debounced, synchronised)
//   sec_carry  in   seconds counter at terminal value 59
//   min_carry  in   minutes counter at terminal value 59
//   sec_en     out  seconds counter increment enable (pulse)
//   min_en     out  minutes counter increment enable (pulse)
//   hour_en    out  hours counter increment enable (pulse)
//   sec_clr    out  seconds counter synchronous clear (pulse)
//   mode       out  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   blink      out  blink indicator for the selected field, 0 in RUN
//   set_active out  1 whenever mode is not RUN
// ============================================================================
module clock_set_ctrl #(
    parameter int TIMEOUT = 10,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink,
    output logic       set_active
);

    // ------------------------------------------------------------------------
    // State encoding doubles as the externally visible mode value.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    // Mode-button sequencing; SET_SEC wraps back to RUN.
    function automatic state_t next_mode(input state_t cur);
        state_t nxt;
        case (cur)
            RUN:      nxt = SET_HOUR;
            SET_HOUR: nxt = SET_MIN;
            SET_MIN:  nxt = SET_SEC;
            default:  nxt = RUN;
        endcase
        return nxt;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic            r_prev_mode;
    logic            r_prev_inc;
    logic [TW-1:0]   r_tcnt;
    logic            r_sec_en;
    logic            r_min_en;
    logic            r_hour_en;
    logic            r_sec_clr;
    logic            r_blink;
    logic            r_set_active;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic   w_mode_edge;
    logic   w_inc_edge;
    logic   w_timeout_hit;
    state_t w_next_state;

    assign w_mode_edge   = btn_mode & ~r_prev_mode;
    assign w_inc_edge    = btn_inc  & ~r_prev_inc;
    // The tick being processed is the one that brings the count to TIMEOUT.
    assign w_timeout_hit = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_next_state  = next_mode(r_state);

    // ------------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            // History registers start high so a button held through reset
            // does not register as a press on release.
            r_prev_mode  <= 1'b1;
            r_prev_inc   <= 1'b1;
            r_tcnt       <= '0;
            r_sec_en     <= 1'b0;
            r_min_en     <= 1'b0;
            r_hour_en    <= 1'b0;
            r_sec_clr    <= 1'b0;
            r_blink      <= 1'b0;
            r_set_active <= 1'b0;
        end else begin
            r_prev_mode <= btn_mode;
            r_prev_inc  <= btn_inc;

            // Enables are pulses: cleared unless set again below.
            r_sec_en  <= 1'b0;
            r_min_en  <= 1'b0;
            r_hour_en <= 1'b0;
            r_sec_clr <= 1'b0;

            case (r_state)
                RUN: begin
                    r_tcnt <= '0;
                    // The tick cascade still fires when a mode edge
                    // coincides with the tick.
                    if (tick) begin
                        r_sec_en  <= 1'b1;
                        r_min_en  <= sec_carry;
                        r_hour_en <= sec_carry & min_carry;
                    end
                    if (w_mode_edge) begin
                        r_state      <= SET_HOUR;
                        r_blink      <= 1'b1;
                        r_set_active <= 1'b1;
                    end else begin
                        r_blink      <= 1'b0;
                        r_set_active <= 1'b0;
                    end
                end

                default: begin
                    if (w_mode_edge) begin
                        // Mode edge has priority over a simultaneous
                        // increment; entering any SET field restarts the
                        // blink in its visible phase.
                        r_state      <= w_next_state;
                        r_tcnt       <= '0;
                        r_blink      <= (w_next_state != RUN);
                        r_set_active <= (w_next_state != RUN);
                    end else if (w_inc_edge) begin
                        r_tcnt <= '0;
                        case (r_state)
                            SET_HOUR: r_hour_en <= 1'b1;
                            SET_MIN:  r_min_en  <= 1'b1;
                            default:  r_sec_clr <= 1'b1;
                        endcase
                        if (tick) begin
                            r_blink <= ~r_blink;
                        end
                    end else if (tick) begin
                        if (w_timeout_hit) begin
                            r_state      <= RUN;
                            r_tcnt       <= '0;
                            r_blink      <= 1'b0;
                            r_set_active <= 1'b0;
                        end else begin
                            r_tcnt  <= r_tcnt + 1'b1;
                            r_blink <= ~r_blink;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sec_en     = r_sec_en;
    assign min_en     = r_min_en;
    assign hour_en    = r_hour_en;
    assign sec_clr    = r_sec_clr;
    assign mode       = r_state;
    assign blink      = r_blink;
    assign set_active = r_set_active;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ============================================================================
// tb_clock_set_ctrl
// Directed scenarios plus a randomized run for clock_set_ctrl, compared
// against a behavioural model of the controller kept in this file.
// ============================================================================
module tb_clock_set_ctrl;

    localparam int TIMEOUT = 10;
    localparam int TW      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_carry = 1'b0;
    logic       min_carry = 1'b0;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;
    logic       set_active;

    always #5 clk = ~clk;

    clock_set_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec_carry  (sec_carry),
        .min_carry  (min_carry),
        .sec_en     (sec_en),
        .min_en     (min_en),
        .hour_en    (hour_en),
        .sec_clr    (sec_clr),
        .mode       (mode),
        .blink      (blink),
        .set_active (set_active)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ------------------------------------------------------------------------
    // Behavioural model: which field is being set, how many idle ticks have
    // elapsed, blink phase, and the pulses expected in the following cycle.
    // ------------------------------------------------------------------------
    int m_mode;
    int m_cnt;
    bit m_pm, m_pi, m_blink;
    bit e_sec, e_min, e_hour, e_clr;

    logic [7:0] dut_v;
    assign dut_v = {sec_en, min_en, hour_en, sec_clr, blink, set_active, mode};

    function automatic logic [7:0] exp_vec();
        return {e_sec, e_min, e_hour, e_clr, m_blink, (m_mode != 0), 2'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pm = 1'b1; m_pi = 1'b1; m_blink = 1'b0;
        e_sec = 1'b0; e_min = 1'b0; e_hour = 1'b0; e_clr = 1'b0;
    endtask

    task automatic model_update(input bit t, bm, bi, sc, mc);
        bit me, ie;
        me = bm && !m_pm;
        ie = bi && !m_pi;
        e_sec = 1'b0; e_min = 1'b0; e_hour = 1'b0; e_clr = 1'b0;
        if (m_mode == 0) begin
            if (t) begin
                e_sec  = 1'b1;
                e_min  = sc;
                e_hour = sc && mc;
            end
            m_cnt = 0;
            if (me) begin m_mode = 1; m_blink = 1'b1; end
            else m_blink = 1'b0;
        end else if (me) begin
            m_mode  = (m_mode + 1) % 4;
            m_blink = (m_mode != 0);
            m_cnt   = 0;
        end else begin
            if (t) m_blink = !m_blink;
            if (ie) begin
                m_cnt = 0;
                if (m_mode == 1) e_hour = 1'b1;
                else if (m_mode == 2) e_min = 1'b1;
                else e_clr = 1'b1;
            end else if (t) begin
                m_cnt++;
                if (m_cnt >= TIMEOUT) begin
                    m_mode = 0; m_blink = 1'b0; m_cnt = 0;
                end
            end
        end
        m_pm = bm;
        m_pi = bi;
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model,
    // and leave time positioned 1 ns after the edge for sampling.
    task automatic step(input bit t, bm, bi, sc, mc);
        tick = t; btn_mode = bm; btn_inc = bi; sec_carry = sc; min_carry = mc;
        @(posedge clk);
        model_update(t, bm, bi, sc, mc);
        #1;
    endtask

    task automatic press_mode();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // Holds reset across two edges and releases it just after an edge.
    task automatic do_reset(input bit bm);
        tick = 0; btn_mode = bm; btn_inc = 0; sec_carry = 0; min_carry = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        tick = 0; btn_mode = 0; btn_inc = 0; sec_carry = 0; min_carry = 0;
        rst = 1'b0;
        #3;
        n_total++;
        if (dut_v !== 8'h00) $display("FAIL reset_outputs: got %b expected %b", dut_v, 8'h00);
        else n_pass++;
        do_reset(0);
        step(0, 0, 0, 0, 0);
        n_total++;
        if (dut_v !== exp_vec()) $display("FAIL reset_idle: got %b expected %b", dut_v, exp_vec());
        else n_pass++;
    endtask

    task automatic test_run_ticks();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0);
            if (sec_en) pulses++;
            n_total++;
            if ({sec_en, min_en, hour_en, mode} !== 5'b10000)
                $display("FAIL run_tick%0d: got %b expected %b", k, {sec_en, min_en, hour_en, mode}, 5'b10000);
            else n_pass++;
            step(0, 0, 0, 0, 0);
            if (sec_en) pulses++;
            n_total++;
            if (dut_v !== exp_vec()) $display("FAIL run_tick_after%0d: got %b expected %b", k, dut_v, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (pulses !== 3) $display("FAIL run_pulse_count: got %0d expected %0d", pulses, 3);
        else n_pass++;
    endtask

    task automatic test_cascade();
        step(1, 0, 0, 1, 1);
        n_total++;
        if ({sec_en, min_en, hour_en} !== 3'b111)
            $display("FAIL cascade_full: got %b expected %b", {sec_en, min_en, hour_en}, 3'b111);
        else n_pass++;
        step(0, 0, 0, 1, 1);
        n_total++;
        if ({sec_en, min_en, hour_en} !== 3'b000)
            $display("FAIL cascade_no_tick: got %b expected %b", {sec_en, min_en, hour_en}, 3'b000);
        else n_pass++;
        step(1, 0, 0, 1, 0);
        n_total++;
        if ({sec_en, min_en, hour_en} !== 3'b110)
            $display("FAIL cascade_min_only: got %b expected %b", {sec_en, min_en, hour_en}, 3'b110);
        else n_pass++;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_set_fields();
        int nh, ns, nc, nm;
        press_mode();
        n_total++;
        if ({mode, blink, set_active} !== 4'b0111)
            $display("FAIL set_hour_entry: got %b expected %b", {mode, blink, set_active}, 4'b0111);
        else n_pass++;
        nh = 0; ns = 0;
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 1, 1, 1); if (hour_en) nh++; if (sec_en) ns++;
            step(0, 0, 0, 1, 1); if (hour_en) nh++; if (sec_en) ns++;
            step(1, 0, 0, 1, 1); if (hour_en) nh++; if (sec_en) ns++;
            step(0, 0, 0, 0, 0); if (hour_en) nh++; if (sec_en) ns++;
        end
        n_total++;
        if (nh !== 2 || ns !== 0 || mode !== 2'd1)
            $display("FAIL set_hour_inc: got hour=%0d sec=%0d mode=%0d expected 2 0 1", nh, ns, mode);
        else n_pass++;
        press_mode();
        press_mode();
        n_total++;
        if (dut_v !== exp_vec() || mode !== 2'd3)
            $display("FAIL set_sec_entry: got %b expected %b", dut_v, exp_vec());
        else n_pass++;
        nc = 0; ns = 0; nm = 0;
        step(1, 0, 1, 1, 1); if (sec_clr) nc++; if (sec_en) ns++; if (min_en || hour_en) nm++;
        step(0, 0, 0, 0, 0); if (sec_clr) nc++; if (sec_en) ns++; if (min_en || hour_en) nm++;
        n_total++;
        if (nc !== 1 || ns !== 0 || nm !== 0)
            $display("FAIL set_sec_clr: got clr=%0d sec=%0d other=%0d expected 1 0 0", nc, ns, nm);
        else n_pass++;
        press_mode();
        n_total++;
        if ({mode, blink, set_active} !== 4'b0000)
            $display("FAIL set_exit: got %b expected %b", {mode, blink, set_active}, 4'b0000);
        else n_pass++;
    endtask

    task automatic test_timeout();
        press_mode();
        press_mode();
        for (int k = 1; k <= TIMEOUT; k++) begin
            logic [2:0] want;
            step(1, 0, 0, 0, 0);
            want = (k < TIMEOUT) ? {2'd2, (k % 2 == 0)} : 3'b000;
            n_total++;
            if ({mode, blink} !== want)
                $display("FAIL timeout_tick%0d: got %b expected %b", k, {mode, blink}, want);
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
        // Second pass: an increment on tick 9 restarts the count.
        press_mode();
        press_mode();
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        step(1, 0, 1, 0, 0);
        n_total++;
        if ({mode, min_en} !== 3'b101)
            $display("FAIL timeout_inc_tick9: got %b expected %b", {mode, min_en}, 3'b101);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(1, 0, 0, 0, 0);
            n_total++;
            if (mode !== ((k < TIMEOUT) ? 2'd2 : 2'd0) || dut_v !== exp_vec())
                $display("FAIL timeout_restart%0d: got %b expected %b", k, dut_v, exp_vec());
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_simultaneous();
        step(0, 1, 1, 0, 0);
        n_total++;
        if ({mode, sec_en, min_en, hour_en, sec_clr} !== 6'b010000)
            $display("FAIL simul_mode_inc: got %b expected %b", {mode, sec_en, min_en, hour_en, sec_clr}, 6'b010000);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        press_mode(); press_mode(); press_mode();
        n_total++;
        if (mode !== 2'd0) $display("FAIL simul_back_run: got %0d expected %0d", mode, 0);
        else n_pass++;
        step(1, 1, 0, 0, 0);
        n_total++;
        if ({mode, sec_en} !== 3'b011)
            $display("FAIL simul_tick_mode: got %b expected %b", {mode, sec_en}, 3'b011);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        press_mode(); press_mode(); press_mode();
    endtask

    task automatic test_hold();
        int nh;
        press_mode();
        nh = 0;
        for (int k = 0; k < 50; k++) begin
            step(0, 0, 1, 0, 0);
            if (hour_en) nh++;
        end
        step(0, 0, 0, 0, 0);
        n_total++;
        if (nh !== 1) $display("FAIL hold_inc: got %0d pulses expected %0d", nh, 1);
        else n_pass++;
        press_mode(); press_mode(); press_mode();
        n_total++;
        if (dut_v !== exp_vec() || mode !== 2'd0)
            $display("FAIL hold_exit: got %b expected %b", dut_v, exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_hold();
        do_reset(1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
        n_total++;
        if (mode !== 2'd0 || set_active !== 1'b0)
            $display("FAIL reset_hold_mode: got mode=%0d act=%0d expected 0 0", mode, set_active);
        else n_pass++;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        press_mode(); press_mode(); press_mode();
        step(0, 0, 1, 0, 0);
        n_total++;
        if ({mode, sec_clr} !== 3'b111)
            $display("FAIL async_pre: got %b expected %b", {mode, sec_clr}, 3'b111);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (dut_v !== 8'h00) $display("FAIL async_reset: got %b expected %b", dut_v, 8'h00);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        n_total++;
        if (dut_v !== exp_vec()) $display("FAIL async_after: got %b expected %b", dut_v, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        bit bm, bi;
        int den, errs;
        bm = 0; bi = 0; errs = 0;
        for (int i = 0; i < 3000; i++) begin
            den = (i < 1500) ? 6 : 80;
            if ($urandom_range(0, den - 1) == 0) bm = !bm;
            if ($urandom_range(0, den - 1) == 0) bi = !bi;
            step(($urandom_range(0, 3) == 0), bm, bi, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            n_total++;
            if (dut_v !== exp_vec()) begin
                errs++;
                if (errs <= 10) $display("FAIL random_cycle%0d: got %b expected %b", i, dut_v, exp_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_cascade();
        test_set_fields();
        test_timeout();
        test_simultaneous();
        test_hold();
        test_reset_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Sequencing controller for the calendar's chained time counters (seconds MOD 60, minutes MOD 60, hours MOD 24).
- In run mode it turns the 1 Hz tick and counter carries into per-counter increment enables.
- In set mode it suppresses the tick cascade, routes a user increment button to one selected field, drives a blink indicator, and returns to run after an inactivity timeout.
- Sits between the debounced button synchroniser and the counter chain; the counters themselves are separate blocks with enable and synchronous-clear inputs.

Parameters:
TIMEOUT, 10, number of ticks without a button edge after which set mode exits to run
TW, 4, width of the timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
tick  input  1  one-cycle pulse, once per second
btn_mode  input  1  mode button level, debounced and synchronised upstream
btn_inc  input  1  increment button level, debounced and synchronised upstream
sec_carry  input  1  seconds counter at terminal value (59), combinational from the counter
min_carry  input  1  minutes counter at terminal value (59)
sec_en  output  1  seconds counter increment enable, one-cycle pulse
min_en  output  1  minutes counter increment enable, one-cycle pulse
hour_en  output  1  hours counter increment enable, one-cycle pulse
sec_clr  output  1  seconds counter synchronous clear, one-cycle pulse
mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC
blink  output  1  display blink for the selected field; 0 in RUN
set_active  output  1  1 when mode != RUN

Behaviour:
- Reset (rst=0, asynchronous):
  - state RUN; sec_en, min_en, hour_en, sec_clr, blink, set_active all 0; mode=0; timeout counter 0.
  - Button history registers reset to 1, so a button held through reset produces no edge.
- Edge detection:
  - mode_edge = btn_mode & ~prev_mode; inc_edge = btn_inc & ~prev_inc.
  - prev registers update every cycle.
- All outputs are registered. An event in cycle N produces its output pulse in cycle N+1, exactly one cycle wide.
- RUN, on a cycle with tick=1:
  - sec_en <= 1
  - min_en <= sec_carry
  - hour_en <= sec_carry & min_carry
  - Carries are sampled in the same cycle as the tick.
- SET states:
  - tick never produces enables.
  - inc_edge produces one pulse on the selected field only, with no cascade:
    - SET_HOUR: hour_en
    - SET_MIN: min_en
    - SET_SEC: sec_clr (seconds zeroed), not sec_en
- FSM, advanced on mode_edge: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- Simultaneous events:
  - mode_edge and inc_edge in the same cycle: mode_edge wins and inc_edge is ignored.
  - tick and inc_edge in a SET state: the increment is performed and the timeout counter resets to 0.
  - tick and mode_edge while in RUN: the run enables for that tick still fire, and the state moves to SET_HOUR.
- Timeout:
  - In SET states, each tick increments the counter; any mode_edge or inc_edge clears it to 0.
  - A tick that brings the count to TIMEOUT forces the state to RUN and clears the counter.
  - Entering RUN from any path clears the counter.
- Blink:
  - Set to 1 on entry into any SET state, including SET->SET transitions.
  - Toggles on each tick while in a SET state; forced to 0 in RUN.
- set_active = (mode != 0), registered alongside mode.
- Reset asserted mid-operation aborts any pending pulse; the counters keep their values because they are reset separately.

Test Plan:
- Reset, then 3 ticks with sec_carry=0 -> exactly 3 one-cycle sec_en pulses, each 1 cycle after its tick; min_en and hour_en stay 0; mode=0.
- RUN, tick with sec_carry=1, min_carry=1 -> sec_en, min_en and hour_en all 1 in the same cycle (tick+1); with min_carry=0, only sec_en and min_en are 1.
- Mode pressed once, then inc pressed twice -> mode=1, two hour_en pulses, no sec_en despite ticks; press mode twice more, then inc -> mode=3, sec_clr pulse, sec_en stays 0.
- Enter SET_MIN, then apply 10 ticks with no buttons -> mode returns to 0 on the 10th tick (+1 cycle); blink toggles 1,0,1,... per tick and is 0 after exit. Repeat with an inc press at tick 9 -> no exit until 10 further ticks.
- btn_mode and btn_inc rising in the same cycle from RUN -> mode=1, no enable pulse. Holding btn_inc high for 50 cycles -> only one pulse.
- Hold btn_mode=1 through reset release -> no mode change. Assert rst during SET_SEC -> mode=0, all outputs 0 immediately, without waiting for a clock edge.
